// File: rtl/tile_frame_renderer.sv
// tile_frame_renderer: two-stage tile-grid colour pipeline with per-frame state
// snapshot and double-buffered DDaver colour memory.
module tile_frame_renderer #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int TILE         = 40,
    parameter int COLS         = 16,
    parameter int ROWS         = 12,
    parameter int NUM_BULLETS  = 3,
    parameter int EN_ROWS      = 5,
    parameter int EN_COLS      = 6,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [9:0]                horizCount,
    input  logic [9:0]                vertCount,
    input  logic                      frame_start,
    input  logic [3:0]                blockieee,
    input  logic                      blink_en,
    input  logic [12*NUM_BULLETS-1:0] bullet_color,
    input  logic [4*NUM_BULLETS-1:0]  bullet_x,
    input  logic [4*NUM_BULLETS-1:0]  bullet_y,
    input  logic                      dd_we,
    input  logic [2:0]                dd_row,
    input  logic [2:0]                dd_col,
    input  logic [11:0]               dd_color,
    output logic [11:0]               pixel_rgb,
    output logic                      pixel_valid
);
    localparam int FW = $clog2(BLINK_FRAMES);
    localparam int RW = $clog2(EN_ROWS);
    localparam int CW = $clog2(EN_COLS);

    logic [5:0]                col, row, er, ec;
    logic                      act;
    logic [3:0]                sh_blk;
    logic                      sh_blink;
    logic [12*NUM_BULLETS-1:0] sh_bc;
    logic [4*NUM_BULLETS-1:0]  sh_bx, sh_by;
    logic [FW-1:0]             fcnt;
    logic [11:0]               back  [EN_ROWS][EN_COLS];
    logic [11:0]               front [EN_ROWS][EN_COLS];
    logic [11:0]               nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col         <= '0;
            row         <= '0;
            act         <= 1'b0;
            pixel_rgb   <= '0;
            pixel_valid <= 1'b0;
            sh_blk      <= '0;
            sh_blink    <= 1'b0;
            sh_bc       <= '0;
            sh_bx       <= '0;
            sh_by       <= '0;
            fcnt        <= '0;
            for (int r = 0; r < EN_ROWS; r++)
                for (int c = 0; c < EN_COLS; c++) begin
                    back[r][c]  <= '0;
                    front[r][c] <= '0;
                end
        end else begin
            col         <= 6'(32'(horizCount) / TILE);
            row         <= 6'(32'(vertCount) / TILE);
            act         <= 32'(horizCount) < H_ACTIVE && 32'(vertCount) < V_ACTIVE;
            pixel_rgb   <= nxt;
            pixel_valid <= act;
            if (frame_start) begin
                sh_blk   <= blockieee;
                sh_blink <= blink_en;
                sh_bc    <= bullet_color;
                sh_bx    <= bullet_x;
                sh_by    <= bullet_y;
                front    <= back;
                fcnt     <= 32'(fcnt) == BLINK_FRAMES - 1 ? '0 : fcnt + 1'b1;
            end
            // front copy above reads pre-edge back, so a coincident write waits a frame
            if (dd_we && 32'(dd_row) < EN_ROWS && 32'(dd_col) < EN_COLS)
                back[dd_row[RW-1:0]][dd_col[CW-1:0]] <= dd_color;
        end
    end

    // later assignments override earlier ones, so lowest priority comes first
    always_comb begin
        er  = row >> 1;
        ec  = (col >> 1) - 6'd2;
        nxt = 12'h000;
        if (row[0] && !col[0] && col >= 6'd4 && 32'(er) < EN_ROWS && 32'(ec) < EN_COLS)
            nxt = front[er[RW-1:0]][ec[CW-1:0]];
        for (int i = NUM_BULLETS - 1; i >= 0; i--)
            if (sh_bc[12*i+:12] != 12'h000 && col == 6'(sh_bx[4*i+:4]) && row == 6'(sh_by[4*i+:4]) &&
                32'(sh_bx[4*i+:4]) < COLS && 32'(sh_by[4*i+:4]) < ROWS)
                nxt = sh_bc[12*i+:12];
        if (col == 6'd1 && row == 6'(sh_blk) && 32'(sh_blk) < ROWS &&
            (!sh_blink || 32'(fcnt) < BLINK_FRAMES / 2))
            nxt = 12'hFFF;
        if (col == 6'd0)
            nxt = 12'h282;
        if (!act)
            nxt = 12'h000;
    end
endmodule
